// File: rtl/gfx_compositor.sv
// gfx_compositor
//   Fixed-priority layer compositor sitting between the VGA timing generator
//   and the RGB/sync pins. Layer 0 has the highest priority. The layer enable
//   mask and display mode are shadowed and only updated on a frame-start
//   strobe. Sync and active flags travel through the same pipeline as the
//   colour, so they stay aligned at any depth.
//
// Ports:
//   i_clk, i_reset     system clock, synchronous active-high reset
//   i_pix_clk          pixel strobe (one i_clk wide); all state advances on it
//   i_active           active-video flag
//   i_hs, i_vs         raw active-low syncs
//   i_frame_start      one-strobe pulse at start of vertical blanking
//   i_layer_on         per-layer pixel-hit flags
//   i_layer_rgb        layer k colour at [k*COLOR_W +: COLOR_W]
//   i_layer_mask       requested layer enables (shadowed)
//   i_mode             requested mode (shadowed): normal/solid/bars/debug
//   o_rgb              composited colour
//   o_hs, o_vs         delayed syncs
//   o_active           delayed active flag
//   o_mask_cur         mask currently in effect
module gfx_compositor #(
    parameter int unsigned             NUM_LAYERS  = 4,
    parameter int unsigned             COLOR_W     = 12,
    parameter int unsigned             PIPE_STAGES = 2,
    parameter logic [COLOR_W-1:0]      BG_COLOR    = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_pix_clk,
    input  logic                          i_active,
    input  logic                          i_hs,
    input  logic                          i_vs,
    input  logic                          i_frame_start,
    input  logic [NUM_LAYERS-1:0]         i_layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_rgb,
    input  logic [NUM_LAYERS-1:0]         i_layer_mask,
    input  logic [1:0]                    i_mode,
    output logic [COLOR_W-1:0]            o_rgb,
    output logic                          o_hs,
    output logic                          o_vs,
    output logic                          o_active,
    output logic [NUM_LAYERS-1:0]         o_mask_cur
);

    localparam int unsigned CW       = COLOR_W / 3;
    localparam int unsigned DBG_STEP = ((1 << CW) - 1) / NUM_LAYERS;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_DEBUG  = 2'd3
    } mode_e;

    mode_e                   mode_q, mode_d;
    logic [NUM_LAYERS-1:0]   mask_q, mask_d;
    logic [9:0]              x_cnt_q, x_cnt_d;

    logic [COLOR_W-1:0]      rgb_q [PIPE_STAGES];
    logic [COLOR_W-1:0]      rgb_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]  hs_q, hs_d;
    logic [PIPE_STAGES-1:0]  vs_q, vs_d;
    logic [PIPE_STAGES-1:0]  act_q, act_d;

    logic [NUM_LAYERS-1:0]   hit;
    logic                    found;
    int unsigned             win;
    logic [CW-1:0]           dbg_ch;
    logic [2:0]              bar;
    logic [COLOR_W-1:0]      pix;

    // Winner selection and stage-1 colour, using the shadowed mask/mode so
    // the frame-start pixel itself is still composited with the old values.
    always_comb begin
        hit   = i_layer_on & mask_q;
        found = 1'b0;
        win   = 0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (hit[k] && !found) begin
                found = 1'b1;
                win   = k;
            end
        end
        dbg_ch = CW'((win + 1) * DBG_STEP);
        bar    = x_cnt_q[8:6];

        case (mode_q)
            MODE_NORMAL: pix = found ? i_layer_rgb[win*COLOR_W +: COLOR_W] : BG_COLOR;
            MODE_SOLID:  pix = BG_COLOR;
            MODE_BARS:   pix = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
            MODE_DEBUG:  pix = found ? {3{dbg_ch}} : '0;
            default:     pix = BG_COLOR;
        endcase
        if (!i_active) begin
            pix = '0;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        mask_d  = mask_q;
        x_cnt_d = x_cnt_q;
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        act_d   = act_q;
        if (i_pix_clk) begin
            if (i_frame_start) begin
                mode_d = mode_e'(i_mode);
                mask_d = i_layer_mask;
            end
            if (!i_active) begin
                x_cnt_d = '0;
            end else if (x_cnt_q != '1) begin
                x_cnt_d = x_cnt_q + 10'd1;
            end
            rgb_d[0] = pix;
            hs_d[0]  = i_hs;
            vs_d[0]  = i_vs;
            act_d[0] = i_active;
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                rgb_d[s] = rgb_q[s-1];
                hs_d[s]  = hs_q[s-1];
                vs_d[s]  = vs_q[s-1];
                act_d[s] = act_q[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q  <= MODE_NORMAL;
            mask_q  <= '1;
            x_cnt_q <= '0;
            rgb_q   <= '{default: '0};
            hs_q    <= '1;
            vs_q    <= '1;
            act_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            x_cnt_q <= x_cnt_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            act_q   <= act_d;
        end
    end

    assign o_rgb      = rgb_q[PIPE_STAGES-1];
    assign o_hs       = hs_q[PIPE_STAGES-1];
    assign o_vs       = vs_q[PIPE_STAGES-1];
    assign o_active   = act_q[PIPE_STAGES-1];
    assign o_mask_cur = mask_q;

endmodule
